// File: rtl/token_rally_pkg.sv
// token_rally_pkg: shared state encoding and mode/direction constants for token_rally.
package token_rally_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, FINISH} state_e;
    localparam logic MODE_RING   = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;
    localparam logic UP          = 1'b0;
    localparam logic DOWN        = 1'b1;
endpackage

// File: rtl/rally_timer.sv
// rally_timer: loadable down-counter with enable and zero flag.
module rally_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign zero_o = cnt_q == '0;
    assign cnt_d  = load_i ? load_val_i : (en_i && !zero_o) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/token_rally.sv
// token_rally: N-participant token-passing engine with ring or bounce visiting order.
module token_rally
    import token_rally_pkg::*;
#(
    parameter int N_CHAN  = 2,
    parameter int DELAY_W = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic [DELAY_W-1:0] hold_cycles,
    input  logic [CNT_W-1:0]   max_hits,
    input  logic               abort,
    output logic               busy,
    output logic [N_CHAN-1:0]  token,
    output logic [N_CHAN-1:0]  hit,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic               done
);
    localparam int IW = $clog2(N_CHAN);
    localparam logic [IW-1:0] LAST = IW'(N_CHAN - 1);
    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d, idx_nx;
    logic               dir_q, dir_d, dir_nx;
    logic               mode_q, mode_d;
    logic [DELAY_W-1:0] reload_q, reload_d;
    logic [CNT_W-1:0]   max_q, max_d, cnt_q, cnt_d, cnt_inc;
    logic [N_CHAN-1:0]  oh;
    logic               t_load, t_zero, fire, at_top, at_bot;
    rally_timer #(.W(DELAY_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (t_load),
        .en_i       (state_q == HOLD),
        .load_val_i (reload_d),
        .zero_o     (t_zero)
    );
    assign at_top  = idx_q == LAST;
    assign at_bot  = idx_q == '0;
    // Bounce reverses at either end so an end participant never holds twice in a row.
    assign dir_nx  = (mode_q == MODE_RING) ? dir_q : at_top ? DOWN : at_bot ? UP : dir_q;
    assign idx_nx  = (mode_q == MODE_RING && at_top) ? '0 : (dir_nx == UP) ? idx_q + 1'b1 : idx_q - 1'b1;
    assign oh      = N_CHAN'(1) << idx_q;
    assign fire    = state_q == HOLD && t_zero && !abort;
    assign cnt_inc = cnt_q + 1'b1;
    assign busy    = state_q != IDLE;
    assign token   = (state_q == HOLD) ? oh : '0;
    assign hit     = fire ? oh : '0;
    assign done    = state_q == FINISH && !abort;
    assign hit_cnt = cnt_q;
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        reload_d = reload_q;
        max_d    = max_q;
        cnt_d    = cnt_q;
        t_load   = 1'b0;
        case (state_q)
            IDLE: if (start && !abort) begin
                state_d  = (max_hits == '0) ? FINISH : HOLD;
                idx_d    = '0;
                dir_d    = UP;
                mode_d   = mode;
                reload_d = (hold_cycles == '0) ? '0 : hold_cycles - 1'b1;
                max_d    = max_hits;
                cnt_d    = '0;
                t_load   = 1'b1;
            end
            HOLD: if (abort) state_d = IDLE;
                else if (t_zero) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == max_q) ? FINISH : HOLD;
                    idx_d   = idx_nx;
                    dir_d   = dir_nx;
                    t_load  = 1'b1;
                end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            dir_q    <= UP;
            mode_q   <= MODE_RING;
            reload_q <= '0;
            max_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            reload_q <= reload_d;
            max_q    <= max_d;
            cnt_q    <= cnt_d;
        end
endmodule

// File: tb/tb_token_rally.sv
// tb_token_rally: three token_rally instances (N=2,3,4) driven in lockstep and checked against a cycle-count model.
module tb_token_rally;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, abort = 1'b0;
    logic [7:0] hold_cycles = '0, max_hits = '0;
    logic       busy2, busy3, busy4, done2, done3, done4;
    logic [1:0] tok2, hit2;
    logic [2:0] tok3, hit3;
    logic [3:0] tok4, hit4;
    logic [7:0] cnt2, cnt3, cnt4;
    int checks = 0, fails = 0, tcur = -1, done_at = -1;
    bit mrun = 0, mmode = 0;
    int mc = 0, mh = 1, mm = 0, mlast = 0;
    typedef struct {logic md; int hold; int mx; int ab; int st2; int ecnt; int edone;} rec_t;
    rec_t tab [9];

    always #5 clk = ~clk;

    token_rally #(.N_CHAN(2)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .hold_cycles(hold_cycles),
        .max_hits(max_hits), .abort(abort), .busy(busy2), .token(tok2), .hit(hit2), .hit_cnt(cnt2), .done(done2));
    token_rally #(.N_CHAN(3)) u3 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .hold_cycles(hold_cycles),
        .max_hits(max_hits), .abort(abort), .busy(busy3), .token(tok3), .hit(hit3), .hit_cnt(cnt3), .done(done3));
    token_rally #(.N_CHAN(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .hold_cycles(hold_cycles),
        .max_hits(max_hits), .abort(abort), .busy(busy4), .token(tok4), .hit(hit4), .hit_cnt(cnt4), .done(done4));

    // Expected {busy, done, hit_cnt, token, hit} for an n-participant engine, from rally cycle number alone.
    function automatic logic [17:0] expv(int n);
        int k, p, h;
        logic [3:0] o;
        if (!mrun) return {2'b00, 8'(mlast), 8'h00};
        if (mc <= mm * mh) begin
            k = (mc - 1) / mh;
            p = mmode ? k % (2 * n - 2) : k % n;
            h = (p < n) ? p : 2 * n - 2 - p;
            o = 4'b0001 << h;
            return {1'b1, 1'b0, 8'((mc - 1) / mh), o, (mc % mh == 0 && !abort) ? o : 4'h0};
        end
        return {1'b1, !abort, 8'(mm), 8'h00};
    endfunction

    task automatic chk(string nm, int n, logic [17:0] act);
        logic [17:0] e;
        e = expv(n);
        checks++;
        if (act !== e) begin
            fails++;
            $display("FAIL %s t=%0d got=%h exp=%h", nm, tcur, act, e);
        end
    endtask

    task automatic chk_all();
        chk("u2", 2, {busy2, done2, cnt2, 4'(tok2), 4'(hit2)});
        chk("u3", 3, {busy3, done3, cnt3, 4'(tok3), 4'(hit3)});
        chk("u4", 4, {busy4, done4, cnt4, tok4, hit4});
    endtask

    task automatic cycle();
        @(negedge clk);
        chk_all();
        if (done4 && done_at < 0) done_at = tcur;
        @(posedge clk);
        if (mrun) begin
            if (abort) begin
                mrun = 0;
                mlast = (mc <= mm * mh) ? (mc - 1) / mh : mm;
            end else if (mc == mm * mh + 1) begin
                mrun = 0;
                mlast = mm;
            end else mc++;
        end else if (start && !abort) begin
            mrun = 1; mc = 1; mmode = mode; mm = max_hits;
            mh = (hold_cycles == 0) ? 1 : hold_cycles;
        end
        #1;
    endtask

    task automatic run_rec(rec_t r);
        bit ended = 0;
        done_at = -1;
        for (int t = 0; t < 400; t++) begin
            tcur = t;
            start = (t == 0) || (t == r.st2);
            abort = (t == r.ab);
            if (t == 0) begin
                mode = r.md; hold_cycles = 8'(r.hold); max_hits = 8'(r.mx);
            end else begin
                mode = 1'($urandom); hold_cycles = 8'($urandom); max_hits = 8'($urandom);
            end
            cycle();
            if (t > 0 && !mrun) begin ended = 1; break; end
        end
        start = 0; abort = 0;
        tcur = -2;
        cycle();
        checks++;
        if (!ended) begin fails++; $display("FAIL timeout rally still busy"); end
        checks++;
        if (done_at != r.edone) begin fails++; $display("FAIL done_cycle got=%0d exp=%0d", done_at, r.edone); end
        checks++;
        if (cnt4 !== 8'(r.ecnt)) begin fails++; $display("FAIL final_cnt got=%0d exp=%0d", cnt4, r.ecnt); end
    endtask

    initial begin
        tab[0] = '{1'b0, 1, 10, -1, -1, 10, 11};
        tab[1] = '{1'b1, 3, 7, -1, -1, 7, 22};
        tab[2] = '{1'b0, 0, 4, -1, -1, 4, 5};
        tab[3] = '{1'b1, 2, 0, -1, -1, 0, 1};
        tab[4] = '{1'b0, 5, 10, 12, 8, 2, -1};
        tab[5] = '{1'b0, 3, 5, 0, -1, 2, -1};
        tab[6] = '{1'b1, 2, 3, 7, -1, 3, -1};
        tab[7] = '{1'b1, 1, 9, -1, -1, 9, 10};
        tab[8] = '{1'b0, 2, 1, -1, -1, 1, 3};
        #12;
        chk_all();
        rst_n = 1'b1;
        @(posedge clk); #1;
        foreach (tab[i]) run_rec(tab[i]);
        for (int i = 0; i < 25; i++) begin
            rec_t r;
            int h, tot;
            r.md = 1'($urandom); r.hold = $urandom_range(0, 4); r.mx = $urandom_range(0, 8);
            r.ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : -1;
            r.st2 = $urandom_range(1, 20);
            h = (r.hold == 0) ? 1 : r.hold;
            tot = r.mx * h + 1;
            if (r.ab < 0 || r.ab > tot) begin r.ecnt = r.mx; r.edone = tot; end
            else begin r.edone = -1; r.ecnt = (r.ab <= r.mx * h) ? (r.ab - 1) / h : r.mx; end
            run_rec(r);
        end
        start = 1; mode = 0; hold_cycles = 8'd2; max_hits = 8'd5; tcur = 0;
        cycle();
        start = 0;
        for (int t = 1; t < 5; t++) begin tcur = t; cycle(); end
        #2 rst_n = 1'b0;
        #1;
        mrun = 0; mlast = 0; tcur = -3;
        checks++;
        if ({busy2, busy3, busy4, tok2, tok3, tok4, cnt2, cnt3, cnt4} !== '0) begin
            fails++;
            $display("FAIL async_reset got=%h exp=0", {busy2, busy3, busy4, tok2, tok3, tok4, cnt2, cnt3, cnt4});
        end
        rst_n = 1'b1;
        run_rec('{1'b0, 2, 5, -1, -1, 5, 11});
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
